note_scheduler: RTL and testbench
=================================

// Module: note_scheduler
// PURPOSE
//  Sequences the DDR note field: times the beat, decides per beat which of the 4
//  arrow columns receives a new note, and drives the top-row PRELIGHT inputs of the
//  column light chains. Also emits the row-advance strobe. Sits between game-control
//  FSM (START/PAUSE/speed) and the four column light chains.
// PARAMETERS
//  BEAT_DIV  12_500_000  CLOCK cycles per beat at SPEED=0 (0.25 s @ 50 MHz); >= 16
//  SONG_LEN  64          beats during which notes may spawn
//  ROWS      8           rows per column; drain beats after song ends
//  SEED      8'hA5       LFSR reset/start value; must be nonzero
// PORTS
//  CLOCK     in   1  system clock
//  RESET     in   1  asynchronous, active-high reset
//  START     in   1  level; rising edge (internally detected) starts/restarts a song
//  PAUSE     in   1  level; 1 freezes all timing
//  SPEED     in   2  beat-rate select: period = BEAT_DIV >> SPEED; sampled at start only
//  SPAWN     out  4  one-hot/zero column note vector -> top-row PRELIGHT; held per beat
//  STEP      out  1  one-CLOCK pulse per beat; light chains shift on this
//  PLAYING   out  1  1 in PLAY or DRAIN
//  DONE      out  1  1 in DONE
//  BEAT_CNT  out  8  beats elapsed in current song (saturates at 255)
// BEHAVIOUR
//  Reset (async): state=IDLE, SPAWN=0, STEP=0, PLAYING=0, DONE=0, BEAT_CNT=0,
//   divider=0, LFSR=SEED, start-edge register=0. Reset mid-song aborts immediately.
//  States: IDLE -> PLAY on START rise; PLAY -> DRAIN after beat SONG_LEN;
//   DRAIN -> DONE after ROWS further beats; DONE -> PLAY on START rise.
//   START rise in PLAY/DRAIN ignored.
//  Start: latch period=BEAT_DIV>>SPEED, clear divider, BEAT_CNT=0, LFSR=SEED,
//   SPAWN=0. First STEP occurs `period` cycles after the START-rise cycle.
//  Divider: counts 0..period-1 while PLAY/DRAIN and PAUSE=0; at period-1 wraps to 0,
//   STEP=1 for that next cycle only. PAUSE=1: divider, LFSR, counters frozen,
//   STEP=0, SPAWN held. PAUSE asserted on the terminal cycle suppresses that STEP.
//  Beat update (on the cycle STEP is asserted, registered with it):
//   LFSR 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), advanced once.
//   PLAY: SPAWN = (lfsr[7:6]!=2'b00) ? (4'b0001 << lfsr[1:0]) : 4'b0000, using the
//    pre-advance LFSR value; BEAT_CNT+1 (saturating).
//   DRAIN: SPAWN=0; drain counter +1.
//   Beat SONG_LEN's spawn is the last; transition to DRAIN at that STEP.
//   Transition to DONE at the ROWS-th drain STEP; SPAWN=0 in DONE/IDLE.
//  SPAWN never has more than one bit set. STEP never asserted in IDLE/DONE.
//  Simultaneous START rise and PAUSE: start occurs; divider frozen until PAUSE=0.
//  Widths: divider 24 bits; period >= 2 required (BEAT_DIV>>3 >= 2).
// STRUCTURE
//  Shared header ddr_defs.vh: state encodings (IDLE=0, PLAY=1, DRAIN=2, DONE=3),
//   NUM_COLS=4, LFSR tap constant; reused by column chains and score logic.
//  Sub-module beat_divider (CLOCK, RESET, EN, CLR, PERIOD[23:0] -> TICK);
//   FSM, LFSR and counters stay in note_scheduler.
// TESTING  (bench params BEAT_DIV=16, SONG_LEN=8, ROWS=3, SEED=8'hA5)
//  Reset mid-PLAY -> all outputs 0 in same cycle, state IDLE; no STEP until next START.
//  START rise, SPEED=0 -> STEP first at cycle 16 after rise, then every 16 cycles;
//   SPEED=2 -> every 4.
//  Full song -> exactly 8 STEPs with SPAWN from golden LFSR model (<=1 bit set),
//   then 3 STEPs with SPAWN=0, then DONE=1, PLAYING=0, BEAT_CNT=8.
//  PAUSE for 40 cycles mid-beat -> STEP delayed exactly 40 cycles; SPAWN/BEAT_CNT unchanged.
//  START re-pulsed during PLAY -> ignored; START in DONE -> restart, BEAT_CNT=0, LFSR=SEED.
//  SPEED changed during PLAY -> period unchanged until next start.

Source files
------------

// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the note field: scheduler state encoding, column
// count, divider width and the note LFSR step function.
package note_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  localparam int NUM_COLS = 4;
  localparam int DIV_W    = 24;

  // x^8+x^6+x^5+x^4+1 -> feedback from register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/note_scheduler_beat_divider.sv
// Beat divider: counts 0..PERIOD-1 while EN, wrapping at PERIOD-1.
//  CLOCK, RESET : clock, async active-high reset
//  EN           : count enable (playing and not paused)
//  CLR          : synchronous clear, wins over EN
//  PERIOD       : cycles per beat (>= 2)
//  TICK         : combinational, high on the enabled terminal cycle; the
//                 owner registers it so beat state updates with the strobe
module beat_divider #(
  parameter int W = 24
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         CLR,
  input  logic [W-1:0] PERIOD,
  output logic         TICK
);

  logic [W-1:0] cnt;
  logic         term;

  assign term = (cnt == PERIOD - W'(1));
  assign TICK = EN && !CLR && term;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)      cnt <= '0;
    else if (CLR)   cnt <= '0;
    else if (EN)    cnt <= term ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: times the beat, picks at most one arrow column per beat
// for a new note and strobes the column light chains.
//  CLOCK, RESET : clock, async active-high reset
//  START        : level; rising edge starts a song from IDLE or DONE
//  PAUSE        : level; freezes divider, LFSR and counters
//  SPEED        : beat period = BEAT_DIV >> SPEED, latched at start
//  SPAWN        : zero/one-hot column vector, held between beats
//  STEP         : one-cycle pulse per beat
//  PLAYING      : song running (PLAY or DRAIN)
//  DONE         : song finished
//  BEAT_CNT     : beats elapsed in this song, saturating
// SONG_LEN and ROWS must fit in 8 bits.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int         BEAT_DIV = 12_500_000,
  parameter int         SONG_LEN = 64,
  parameter int         ROWS     = 8,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                START,
  input  logic                PAUSE,
  input  logic [1:0]          SPEED,
  output logic [NUM_COLS-1:0] SPAWN,
  output logic                STEP,
  output logic                PLAYING,
  output logic                DONE,
  output logic [7:0]          BEAT_CNT
);

  localparam logic [7:0] LAST_BEAT  = 8'(SONG_LEN - 1);
  localparam logic [7:0] LAST_DRAIN = 8'(ROWS - 1);

  sched_state_t     state, state_nxt;
  logic             start_q, start_rise, go, active, tick;
  logic [DIV_W-1:0] period;
  logic [7:0]       lfsr, drain_cnt;

  assign start_rise = START && !start_q;
  assign active     = (state == S_PLAY) || (state == S_DRAIN);
  // START rise only counts when no song is running
  assign go         = start_rise && !active;

  beat_divider #(.W(DIV_W)) u_div (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .EN     (active && !PAUSE),
    .CLR    (go),
    .PERIOD (period),
    .TICK   (tick)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_rise)                     state_nxt = S_PLAY;
      S_PLAY:         if (tick && BEAT_CNT == LAST_BEAT)  state_nxt = S_DRAIN;
      S_DRAIN:        if (tick && drain_cnt == LAST_DRAIN) state_nxt = S_DONE;
      default:                                            state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PLAYING = active;
    DONE    = (state == S_DONE);
  end

  // Beat datapath: everything moves on the same edge that raises STEP
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      start_q   <= 1'b0;
      period    <= '0;
      lfsr      <= SEED;
      BEAT_CNT  <= '0;
      drain_cnt <= '0;
      SPAWN     <= '0;
      STEP      <= 1'b0;
    end else begin
      start_q <= START;
      STEP    <= tick;
      if (go) begin
        period    <= DIV_W'(BEAT_DIV) >> SPEED;
        lfsr      <= SEED;
        BEAT_CNT  <= '0;
        drain_cnt <= '0;
        SPAWN     <= '0;
      end else if (tick) begin
        lfsr <= lfsr_next(lfsr);
        if (state == S_PLAY) begin
          // Top two bits gate the note, low two bits choose the column
          SPAWN <= (lfsr[7:6] != 2'b00) ? (NUM_COLS'(1) << lfsr[1:0]) : '0;
          if (BEAT_CNT != 8'hFF) BEAT_CNT <= BEAT_CNT + 8'd1;
        end else begin
          SPAWN     <= '0;
          drain_cnt <= drain_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
module tb_note_scheduler;

  localparam int BD = 16, SL = 8, RW = 3;
  localparam logic [7:0] SD = 8'hA5;

  logic       CLOCK = 1'b0, RESET = 1'b1, START = 1'b0, PAUSE = 1'b0;
  logic [1:0] SPEED = 2'd0;
  logic [3:0] SPAWN;
  logic       STEP, PLAYING, DONE;
  logic [7:0] BEAT_CNT;

  int checks = 0, failures = 0;

  note_scheduler #(.BEAT_DIV(BD), .SONG_LEN(SL), .ROWS(RW), .SEED(SD)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .SPEED(SPEED),
    .SPAWN(SPAWN), .STEP(STEP), .PLAYING(PLAYING), .DONE(DONE), .BEAT_CNT(BEAT_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: polynomial taps listed by exponent, note rule from the
  // pre-advance register value.
  logic [7:0] m_lfsr;
  logic [3:0] prev_spawn;
  logic [7:0] prev_beat;

  function automatic logic [7:0] ref_adv(input logic [7:0] l);
    int taps[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= l[taps[i]-1];
    return {l[6:0], fb};
  endfunction

  function automatic logic [3:0] ref_note(input logic [7:0] l);
    logic [3:0] v = 4'b0000;
    if (l[7:6] != 2'b00) v[l[1:0]] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLOCK); #1;
  endtask

  task automatic start_song();
    START = 1'b1; tick(); START = 1'b0;
    m_lfsr = SD; prev_spawn = 4'b0; prev_beat = 8'd0;
  endtask

  // Edges until STEP; optional START pulse and PAUSE window by edge index.
  task automatic wait_step(input int pulse_at, input int pause_at, input int pause_len,
                           output int n);
    n = 0;
    while (1) begin
      START = (n == pulse_at);
      PAUSE = (n >= pause_at) && (n < pause_at + pause_len);
      tick(); n++;
      if (pause_len > 0 && n == pause_at + pause_len / 2) begin
        chk("pause_spawn_held", 32'(SPAWN), 32'(prev_spawn));
        chk("pause_beat_held", 32'(BEAT_CNT), 32'(prev_beat));
        chk("pause_no_step", 32'(STEP), 32'd0);
      end
      if (STEP) break;
      if (n > 300) begin
        chk("step_timeout", 32'(n), 32'd0);
        break;
      end
    end
    START = 1'b0; PAUSE = 1'b0;
  endtask

  task automatic count_steps(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin tick(); if (STEP) cnt++; end
  endtask

  // Check one PLAY beat against the model, then advance the model.
  task automatic play_beat(input string tag, input int gap, input int exp_gap);
    logic [3:0] e;
    e = ref_note(m_lfsr);
    m_lfsr = ref_adv(m_lfsr);
    chk({tag, "_gap"}, 32'(gap), 32'(exp_gap));
    chk({tag, "_spawn"}, 32'(SPAWN), 32'(e));
    chk({tag, "_beat"}, 32'(BEAT_CNT), 32'(prev_beat) + 1);
    chk({tag, "_onehot"}, 32'($countones(SPAWN) <= 1), 32'd1);
    prev_spawn = e;
    prev_beat  = prev_beat + 8'd1;
  endtask

  initial begin
    int g, c;
    tick(); tick();
    chk("rst_spawn", 32'(SPAWN), 0);
    chk("rst_flags", 32'({STEP, PLAYING, DONE}), 0);
    chk("rst_beat", 32'(BEAT_CNT), 0);
    RESET = 1'b0; tick();
    count_steps(20, c);
    chk("idle_no_step", 32'(c), 0);

    // Song A, period 16, with pauses, ignored restart, late SPEED change
    SPEED = 2'd0;
    start_song();
    chk("a_playing", 32'(PLAYING), 1);
    chk("a_beat0", 32'(BEAT_CNT), 0);
    for (int b = 0; b < SL; b++) begin
      int pa = -1, pl = 0, pu = -1;
      if (b == 2) begin pa = 5;  pl = 40; end
      if (b == 4) begin pa = 15; pl = 3;  end
      if (b == 5) pu = 7;
      if (b == 6) SPEED = 2'd3;
      if (b == 3) begin pa = 1 + int'($urandom_range(0, 10)); pl = int'($urandom_range(2, 30)); end
      wait_step(pu, pa, pl, g);
      play_beat($sformatf("a%0d", b), g, BD + pl);
      chk("a_playing_run", 32'(PLAYING), 1);
    end
    for (int d = 0; d < RW; d++) begin
      wait_step(-1, -1, 0, g);
      chk($sformatf("drain%0d_gap", d), 32'(g), BD);
      chk($sformatf("drain%0d_spawn", d), 32'(SPAWN), 0);
    end
    chk("a_done", 32'(DONE), 1);
    chk("a_not_playing", 32'(PLAYING), 0);
    chk("a_final_beat", 32'(BEAT_CNT), SL);
    count_steps(40, c);
    chk("done_no_step", 32'(c), 0);
    chk("done_spawn", 32'(SPAWN), 0);

    // Song B from DONE, period 4, START rise together with PAUSE
    SPEED = 2'd2; PAUSE = 1'b1;
    start_song();
    chk("b_beat0", 32'(BEAT_CNT), 0);
    chk("b_playing", 32'(PLAYING), 1);
    chk("b_done_clr", 32'(DONE), 0);
    wait_step(-1, 0, 9, g);
    play_beat("b0", g, 4 + 9);
    for (int b = 1; b < 4; b++) begin
      wait_step(-1, -1, 0, g);
      play_beat($sformatf("b%0d", b), g, 4);
    end

    // Asynchronous reset mid-song
    @(posedge CLOCK); #3 RESET = 1'b1; #1;
    chk("arst_spawn", 32'(SPAWN), 0);
    chk("arst_flags", 32'({STEP, PLAYING, DONE}), 0);
    chk("arst_beat", 32'(BEAT_CNT), 0);
    tick(); RESET = 1'b0;
    count_steps(40, c);
    chk("arst_no_step", 32'(c), 0);

    // Song C, period 8, LFSR back at seed
    SPEED = 2'd1;
    start_song();
    for (int b = 0; b < 3; b++) begin
      wait_step(-1, -1, 0, g);
      play_beat($sformatf("c%0d", b), g, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
